decoder_scan_nx2n: RTL
======================

# decoder_scan_nx2n

Registered, parametrised SEL_W-to-2^SEL_W one-hot decoder with enable, four operating modes and an autonomous scan sequencer. It generalises the 2-to-4 decoder for display-digit, keypad-row and chip-select multiplexing. Outputs are registered, so downstream logic sees glitch-free one-hot strobes. Sits between a control register/FSM and the physical select lines.

## Interface
- SEL_W, 2, select width; output count OUT_N = 2**SEL_W (SEL_W 1..6)
- DWELL, 4, cycles each output stays active in scan modes (≥1)
- ACTIVE_LOW, 0, 1 inverts every bit of y (active output driven 0, idle 1)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- en  in  1  1 = decoder active; 0 = all outputs idle, state frozen
- mode  in  2  00 HOLD, 01 PULSE, 10 SCAN_UP, 11 SCAN_DN
- load  in  1  capture sel this cycle
- sel  in  SEL_W  binary index to decode / scan start point
- y  out  OUT_N  one-hot output (polarity per ACTIVE_LOW)
- idx  out  SEL_W  index currently driven
- wrap  out  1  one-cycle pulse on scan wrap-around

## Operation
- Internal state: idx register, dwell counter dcnt (clog2(DWELL) bits, min 1), state enum {OFF, ACTIVE, IDLE_PULSE}.
- Reset: idx=0, dcnt=0, wrap=0, state OFF, y all idle (0, or all ones if ACTIVE_LOW).
- en=0: next cycle state OFF, y idle, wrap=0; idx and dcnt hold. On en returning to 1, y shows one-hot(idx) the next cycle; dcnt restarts at 0.
- HOLD: load → idx=sel, y=one-hot(sel); held until next load or mode change.
- PULSE: load → y=one-hot(sel) for exactly one cycle, then IDLE_PULSE (y idle, idx retains sel). Back-to-back loads give back-to-back pulses.
- SCAN_UP/SCAN_DN: y=one-hot(idx); dcnt increments each enabled cycle; when dcnt==DWELL-1, dcnt←0 and idx←idx±1 mod OUT_N.
- wrap=1 for one cycle exactly when idx steps OUT_N-1→0 (UP) or 0→OUT_N-1 (DN), coincident with the new y.
- Load in scan mode: idx=sel, dcnt=0, no wrap pulse; load wins over a simultaneous dwell expiry.
- Mode change takes effect next cycle; dcnt clears; idx kept. Entering HOLD from PULSE's IDLE_PULSE re-drives one-hot(idx).
- Exactly one y bit is active in ACTIVE state; zero in OFF/IDLE_PULSE.

## Timing
- Inputs sampled at rising clk; all outputs registered, latency 1 cycle from load/en/mode to y/idx.
- DWELL=1: idx advances every cycle.
- rst has priority over en, load and mode in the same cycle.
- No combinational path from any input to any output.

## Structure
- Package decoder_pkg: mode encodings (MODE_HOLD, MODE_PULSE, MODE_SCAN_UP, MODE_SCAN_DN), state enum, OUT_N/width helper function.
- Sub-module onehot_dec: purely combinational, parametrised SEL_W binary → one-hot; instantiated once, followed by polarity XOR and output register in the top.

## Test plan
- Reset then HOLD, SEL_W=2: load sel=2 → y=0100 next cycle and held; en=0 → y=0000, idx stays 2.
- PULSE: loads sel=1 then sel=3 on consecutive cycles → y=0010, 1000, then 0000; idx=3.
- SCAN_UP, DWELL=4: from idx=0 each output active 4 cycles, order 0001,0010,0100,1000,0001; wrap high only on the 1000→0001 cycle.
- SCAN_DN with load sel=1 coinciding with dwell expiry → idx=1, dcnt restarts (y=0010 for full 4 cycles), no wrap; next 0001, then 1000 with wrap.
- ACTIVE_LOW=1, SEL_W=3: reset → y=8'hFF; HOLD load sel=5 → y=8'hDF.
- rst asserted mid-scan with load=1 → y idle, idx=0, wrap=0 next cycle.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared definitions for the scanning one-hot decoder: mode codes,
// controller state and sizing helpers.
package decoder_pkg;

   localparam logic [1:0] MODE_HOLD    = 2'b00;
   localparam logic [1:0] MODE_PULSE   = 2'b01;
   localparam logic [1:0] MODE_SCAN_UP = 2'b10;
   localparam logic [1:0] MODE_SCAN_DN = 2'b11;

   // OFF: disabled/after reset; ACTIVE: one output asserted;
   // IDLE_PULSE: pulse mode between strobes, all outputs idle.
   typedef enum logic [1:0] {
      ST_OFF        = 2'd0,
      ST_ACTIVE     = 2'd1,
      ST_IDLE_PULSE = 2'd2
   } dec_state_e;

   // Number of decoded outputs for a given select width.
   function automatic int out_n(input int sel_w);
      return 1 << sel_w;
   endfunction

   // Dwell counter width; never narrower than one bit so DWELL=1 still
   // has a legal (constant-zero) counter.
   function automatic int cnt_w(input int dwell);
      return (dwell <= 1) ? 1 : $clog2(dwell);
   endfunction

endpackage

// File: rtl/onehot_dec.sv
// Purely combinational binary to one-hot decoder, one comparator per output.
module onehot_dec
   import decoder_pkg::*;
#(
   parameter int  SEL_W = 2,
   localparam int OUT_N = out_n(SEL_W)
) (
   input  logic [SEL_W-1:0] sel,
   output logic [OUT_N-1:0] onehot
);

   genvar gi;
   generate
      for (gi = 0; gi < OUT_N; gi++) begin : g_bit
         assign onehot[gi] = (sel == SEL_W'(gi));
      end
   endgenerate

endmodule

// File: rtl/decoder_scan_nx2n.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with enable, hold/pulse
// modes and an autonomous up/down scan sequencer with per-output dwell.
module decoder_scan_nx2n
   import decoder_pkg::*;
#(
   parameter int  SEL_W      = 2,
   parameter int  DWELL      = 4,
   parameter bit  ACTIVE_LOW = 1'b0,
   localparam int OUT_N      = out_n(SEL_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [SEL_W-1:0] sel,
   output logic [OUT_N-1:0] y,
   output logic [SEL_W-1:0] idx,
   output logic             wrap
);

   localparam int                DCNT_W    = cnt_w(DWELL);
   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DWELL - 1);
   // Idle level of every output line; XOR with it applies the polarity.
   localparam logic [OUT_N-1:0]  IDLE_Y    = {OUT_N{ACTIVE_LOW}};

   logic [SEL_W-1:0]  idx_q, idx_d;
   logic [DCNT_W-1:0] dcnt_q, dcnt_d;
   dec_state_e        state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic              wrap_q, wrap_d;
   logic [OUT_N-1:0]  y_q, y_d;
   logic [OUT_N-1:0]  dec_onehot;
   logic              entering;

   // Decode the index that will be driven next cycle.
   onehot_dec #(
      .SEL_W (SEL_W)
   ) u_onehot_dec (
      .sel    (idx_d),
      .onehot (dec_onehot)
   );

   // Next-state: enable gating, mode behaviour, dwell counting and wrap.
   always_comb begin
      idx_d    = idx_q;
      dcnt_d   = dcnt_q;
      state_d  = state_q;
      wrap_d   = 1'b0;
      mode_d   = mode;
      // Re-entry from disable or a mode switch restarts the dwell period.
      entering = (state_q == ST_OFF) || (mode != mode_q);

      if (!en) begin
         state_d = ST_OFF;
      end else begin
         case (mode)
            MODE_HOLD: begin
               dcnt_d  = '0;
               state_d = ST_ACTIVE;
               if (load) begin
                  idx_d = sel;
               end
            end
            MODE_PULSE: begin
               dcnt_d = '0;
               if (load) begin
                  idx_d   = sel;
                  state_d = ST_ACTIVE;
               end else if (state_q == ST_OFF) begin
                  // Coming back from disable shows the current index once.
                  state_d = ST_ACTIVE;
               end else begin
                  state_d = ST_IDLE_PULSE;
               end
            end
            default: begin
               state_d = ST_ACTIVE;
               if (load) begin
                  // Load overrides any dwell expiry in the same cycle.
                  idx_d  = sel;
                  dcnt_d = '0;
               end else if (entering) begin
                  dcnt_d = '0;
               end else if (dcnt_q == DCNT_LAST) begin
                  dcnt_d = '0;
                  if (mode == MODE_SCAN_UP) begin
                     idx_d  = idx_q + SEL_W'(1);
                     wrap_d = (idx_q == '1);
                  end else begin
                     idx_d  = idx_q - SEL_W'(1);
                     wrap_d = (idx_q == '0);
                  end
               end else begin
                  dcnt_d = dcnt_q + DCNT_W'(1);
               end
            end
         endcase
      end
   end

   // Output word: decoded index when active, otherwise idle level.
   always_comb begin
      y_d = IDLE_Y;
      if (state_d == ST_ACTIVE) begin
         y_d = dec_onehot ^ IDLE_Y;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q   <= '0;
         dcnt_q  <= '0;
         state_q <= ST_OFF;
         mode_q  <= MODE_HOLD;
         wrap_q  <= 1'b0;
         y_q     <= IDLE_Y;
      end else begin
         idx_q   <= idx_d;
         dcnt_q  <= dcnt_d;
         state_q <= state_d;
         mode_q  <= mode_d;
         wrap_q  <= wrap_d;
         y_q     <= y_d;
      end
   end

   assign y    = y_q;
   assign idx  = idx_q;
   assign wrap = wrap_q;

endmodule
